// File: rtl/preemption_arbiter_pkg.sv
// Shared codes for the preemption arbiter: priority sides, phase and light-state
// codes from phase_controller, and the arbiter state encoding.
`timescale 1ns/1ps
package preemption_arbiter_pkg;

  typedef logic [1:0] side_t;

  localparam side_t NO_PRIORITY = 2'd0;
  localparam side_t EAST        = 2'd1;
  localparam side_t WEST        = 2'd2;

  localparam logic [1:0] PHASE_1       = 2'd0;
  localparam logic [1:0] PHASE_2       = 2'd1;
  localparam logic [1:0] EAST_PRIORITY = 2'd2;
  localparam logic [1:0] WEST_PRIORITY = 2'd3;

  localparam logic [3:0] PHASE_1_GREEN   = 4'd0;
  localparam logic [3:0] PHASE_1_YELLOW  = 4'd1;
  localparam logic [3:0] PHASE_1_RED     = 4'd2;
  localparam logic [3:0] PHASE_2_GREEN   = 4'd3;
  localparam logic [3:0] PHASE_2_YELLOW  = 4'd4;
  localparam logic [3:0] PHASE_2_RED     = 4'd5;
  localparam logic [3:0] PRIORITY_GREEN  = 4'd6;
  localparam logic [3:0] PRIORITY_YELLOW = 4'd7;

  localparam logic [1:0] ARB_IDLE    = 2'd0;
  localparam logic [1:0] ARB_OFFER   = 2'd1;
  localparam logic [1:0] ARB_SERVE   = 2'd2;
  localparam logic [1:0] ARB_LOCKOUT = 2'd3;

  function automatic side_t other_side(input side_t side);
    return (side == EAST) ? WEST : EAST;
  endfunction

endpackage

// File: rtl/preemption_arbiter_req_debouncer.sv
// Debounces one raw preemption detector and latches a single pending request
// per assertion; the request stays pending until the arbiter clears it.
`timescale 1ns/1ps
module req_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic clear,
  output logic pending
);

  localparam logic [CNT_W-1:0] TARGET = CNT_W'(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             armed_q, armed_d;
  logic             pending_q, pending_d;

  // The count saturates at TARGET; armed makes a long assertion latch only once.
  // A fresh latch wins over a clear arriving on the same cycle.
  always_comb begin
    cnt_d     = cnt_q;
    armed_d   = armed_q;
    pending_d = pending_q;
    if (clear) pending_d = 1'b0;
    if (!req) begin
      cnt_d   = '0;
      armed_d = 1'b1;
    end else begin
      if (cnt_q < TARGET) cnt_d = cnt_q + CNT_W'(1);
      if (cnt_d == TARGET && armed_q) begin
        pending_d = 1'b1;
        armed_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      armed_q   <= 1'b1;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      armed_q   <= armed_d;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/preemption_arbiter.sv
// East/west emergency-preemption arbiter feeding phase_controller's priority input.
// The priority output is named priority_sel because "priority" is an SV keyword.
`timescale 1ns/1ps
module preemption_arbiter
  import preemption_arbiter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOCKOUT_CYCLES  = 16,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_east,
  input  logic       req_west,
  input  logic [3:0] light_state,
  input  logic [1:0] current_phase,
  output logic [1:0] priority_sel,
  output logic       pending_east,
  output logic       pending_west,
  output logic       served_pulse
);

  localparam logic [CNT_W-1:0] LOCK_INIT =
    (LOCKOUT_CYCLES > 0) ? CNT_W'(LOCKOUT_CYCLES - 1) : '0;

  logic [1:0]       state_q, state_d;
  side_t            offer_side_q, offer_side_d;
  side_t            last_served_q, last_served_d;
  side_t            priority_q, priority_d;
  logic             served_q, served_d;
  logic [CNT_W-1:0] lock_q, lock_d;
  logic             clear_east, clear_west;
  logic             pend_e, pend_w;
  side_t            pick_side;
  logic             offer_taken;

  req_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_east (
    .clk(clk), .rst(rst), .req(req_east), .clear(clear_east), .pending(pend_e)
  );

  req_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_west (
    .clk(clk), .rst(rst), .req(req_west), .clear(clear_west), .pending(pend_w)
  );

  // On a tie the side that was not served last wins, so both sides alternate.
  always_comb begin
    pick_side = WEST;
    if (pend_e && pend_w) pick_side = other_side(last_served_q);
    else if (pend_e)      pick_side = EAST;
  end

  assign offer_taken = ((offer_side_q == EAST) && (current_phase == EAST_PRIORITY)) ||
                       ((offer_side_q == WEST) && (current_phase == WEST_PRIORITY));

  always_comb begin
    state_d       = state_q;
    offer_side_d  = offer_side_q;
    last_served_d = last_served_q;
    priority_d    = priority_q;
    served_d      = 1'b0;
    lock_d        = lock_q;
    clear_east    = 1'b0;
    clear_west    = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if ((pend_e || pend_w) && (light_state != PHASE_2_YELLOW)) begin
          offer_side_d = pick_side;
          priority_d   = pick_side;
          state_d      = ARB_OFFER;
        end
      end
      ARB_OFFER: begin
        // Any phase other than the offered side's priority phase is ignored.
        if (offer_taken) begin
          clear_east    = (offer_side_q == EAST);
          clear_west    = (offer_side_q == WEST);
          last_served_d = offer_side_q;
          served_d      = 1'b1;
          priority_d    = NO_PRIORITY;
          state_d       = ARB_SERVE;
        end
      end
      ARB_SERVE: begin
        if (current_phase == PHASE_1) begin
          if (LOCKOUT_CYCLES == 0) begin
            state_d = ARB_IDLE;
          end else begin
            lock_d  = LOCK_INIT;
            state_d = ARB_LOCKOUT;
          end
        end
      end
      ARB_LOCKOUT: begin
        if (lock_q == '0) state_d = ARB_IDLE;
        else              lock_d  = lock_q - CNT_W'(1);
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ARB_IDLE;
      offer_side_q  <= NO_PRIORITY;
      last_served_q <= WEST;
      priority_q    <= NO_PRIORITY;
      served_q      <= 1'b0;
      lock_q        <= '0;
    end else begin
      state_q       <= state_d;
      offer_side_q  <= offer_side_d;
      last_served_q <= last_served_d;
      priority_q    <= priority_d;
      served_q      <= served_d;
      lock_q        <= lock_d;
    end
  end

  assign priority_sel = priority_q;
  assign pending_east = pend_e;
  assign pending_west = pend_w;
  assign served_pulse = served_q;

endmodule

// File: tb/tb_preemption_arbiter.sv
// Randomized self-checking bench for preemption_arbiter: two instances (default
// parameters, and DEBOUNCE_CYCLES=1 / LOCKOUT_CYCLES=0) against a behavioural model.
`timescale 1ns/1ps
module tb_preemption_arbiter;
  import preemption_arbiter_pkg::*;

  localparam int DCFG [2] = '{4, 1};
  localparam int LCFG [2] = '{16, 0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_east = 1'b0;
  logic       req_west = 1'b0;
  logic [3:0] light_state = PHASE_1_GREEN;
  logic [1:0] current_phase = PHASE_1;

  logic [1:0] pri_o [2];
  logic       pe_o  [2];
  logic       pw_o  [2];
  logic       srv_o [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  preemption_arbiter #(.DEBOUNCE_CYCLES(4), .LOCKOUT_CYCLES(16), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .req_east(req_east), .req_west(req_west),
    .light_state(light_state), .current_phase(current_phase),
    .priority_sel(pri_o[0]), .pending_east(pe_o[0]), .pending_west(pw_o[0]),
    .served_pulse(srv_o[0])
  );

  preemption_arbiter #(.DEBOUNCE_CYCLES(1), .LOCKOUT_CYCLES(0), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .req_east(req_east), .req_west(req_west),
    .light_state(light_state), .current_phase(current_phase),
    .priority_sel(pri_o[1]), .pending_east(pe_o[1]), .pending_west(pw_o[1]),
    .served_pulse(srv_o[1])
  );

  // Behavioural model: consecutive-high run lengths, a mode name and cycles left.
  typedef enum int {M_IDLE, M_OFFER, M_SERVE, M_LOCK} mode_e;
  mode_e      mode      [2];
  int         run_e     [2];
  int         run_w     [2];
  int         lock_left [2];
  bit         m_pe      [2];
  bit         m_pw      [2];
  bit         m_srv     [2];
  logic [1:0] m_pri     [2];
  logic [1:0] m_offer   [2];
  logic [1:0] m_last    [2];

  function automatic void model_reset(int k);
    mode[k] = M_IDLE; run_e[k] = 0; run_w[k] = 0; lock_left[k] = 0;
    m_pe[k] = 1'b0; m_pw[k] = 1'b0; m_srv[k] = 1'b0;
    m_pri[k] = NO_PRIORITY; m_offer[k] = NO_PRIORITY; m_last[k] = WEST;
  endfunction

  function automatic void model_step(int k, logic re, logic rw, logic [3:0] ls, logic [1:0] cp);
    bit npe = m_pe[k];
    bit npw = m_pw[k];
    m_srv[k] = 1'b0;
    case (mode[k])
      M_IDLE: if ((m_pe[k] || m_pw[k]) && ls != PHASE_2_YELLOW) begin
        if (m_pe[k] && m_pw[k]) m_offer[k] = (m_last[k] == EAST) ? WEST : EAST;
        else                    m_offer[k] = m_pe[k] ? EAST : WEST;
        m_pri[k] = m_offer[k];
        mode[k] = M_OFFER;
      end
      M_OFFER: if ((m_offer[k] == EAST && cp == EAST_PRIORITY) ||
                   (m_offer[k] == WEST && cp == WEST_PRIORITY)) begin
        if (m_offer[k] == EAST) npe = 1'b0; else npw = 1'b0;
        m_last[k] = m_offer[k];
        m_srv[k] = 1'b1;
        m_pri[k] = NO_PRIORITY;
        mode[k] = M_SERVE;
      end
      M_SERVE: if (cp == PHASE_1) begin
        if (LCFG[k] == 0) mode[k] = M_IDLE;
        else begin lock_left[k] = LCFG[k]; mode[k] = M_LOCK; end
      end
      M_LOCK: begin
        lock_left[k]--;
        if (lock_left[k] == 0) mode[k] = M_IDLE;
      end
      default: mode[k] = M_IDLE;
    endcase
    run_e[k] = re ? run_e[k] + 1 : 0;
    run_w[k] = rw ? run_w[k] + 1 : 0;
    if (run_e[k] == DCFG[k]) npe = 1'b1;
    if (run_w[k] == DCFG[k]) npw = 1'b1;
    m_pe[k] = npe;
    m_pw[k] = npw;
  endfunction

  task automatic checkEq(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    for (int k = 0; k < 2; k++) begin
      checkEq($sformatf("priority[%0d]", k), pri_o[k], m_pri[k]);
      checkEq($sformatf("pending_east[%0d]", k), {1'b0, pe_o[k]}, {1'b0, m_pe[k]});
      checkEq($sformatf("pending_west[%0d]", k), {1'b0, pw_o[k]}, {1'b0, m_pw[k]});
      checkEq($sformatf("served_pulse[%0d]", k), {1'b0, srv_o[k]}, {1'b0, m_srv[k]});
    end
  endtask

  // Called at a negedge: drive, let one posedge happen, advance the model, compare.
  task automatic applyStimulus(input logic re, input logic rw, input logic [3:0] ls,
                               input logic [1:0] cp);
    req_east = re; req_west = rw; light_state = ls; current_phase = cp;
    @(posedge clk);
    model_step(0, re, rw, ls, cp);
    model_step(1, re, rw, ls, cp);
    @(negedge clk);
    checkOutput();
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
  task automatic doReset();
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checkEq($sformatf("rst_priority[%0d]", k), pri_o[k], 2'd0);
      checkEq($sformatf("rst_pending[%0d]", k), {pe_o[k], pw_o[k]}, 2'b00);
      checkEq($sformatf("rst_served[%0d]", k), {1'b0, srv_o[k]}, 2'b00);
      model_reset(k);
    end
    @(negedge clk);
    rst = 1'b0;
    checkOutput();
  endtask

  initial begin
    logic re, rw;
    logic [1:0] cp;
    logic [3:0] ls;
    model_reset(0);
    model_reset(1);
    repeat (2) @(negedge clk);
    checkEq("reset_priority", pri_o[0], 2'd0);
    checkEq("reset_pending", {pe_o[0], pw_o[0]}, 2'b00);
    rst = 1'b0;

    // LOCKOUT_CYCLES=0 instance: PHASE_1 return goes IDLE, then offers WEST.
    applyStimulus(1, 0, PHASE_1_GREEN, PHASE_1);
    checkEq("d1_latch_east", {1'b0, pe_o[1]}, 2'd1);
    applyStimulus(0, 0, PHASE_1_GREEN, PHASE_1);
    checkEq("d1_offer_east", pri_o[1], 2'd1);
    applyStimulus(0, 0, PRIORITY_GREEN, EAST_PRIORITY);
    checkEq("d1_served", {1'b0, srv_o[1]}, 2'd1);
    applyStimulus(0, 1, PHASE_2_GREEN, PHASE_2);
    checkEq("d1_pending_west", {1'b0, pw_o[1]}, 2'd1);
    applyStimulus(0, 0, PHASE_1_GREEN, PHASE_1);
    checkEq("d1_idle_gap", pri_o[1], 2'd0);
    applyStimulus(0, 0, PHASE_1_GREEN, PHASE_1);
    checkEq("d1_offer_west", pri_o[1], 2'd2);

    // Reset while offering east.
    repeat (4) applyStimulus(1, 1, PHASE_1_GREEN, PHASE_1);
    checkEq("pre_reset_both", {pe_o[0], pw_o[0]}, 2'b11);
    applyStimulus(1, 1, PHASE_1_GREEN, PHASE_1);
    checkEq("pre_reset_offer", pri_o[0], 2'd1);
    doReset();
    applyStimulus(0, 0, PHASE_1_GREEN, PHASE_1);

    // Short pulse must not latch; then tie and alternation after lockout.
    repeat (3) applyStimulus(1, 0, PHASE_1_GREEN, PHASE_1);
    applyStimulus(0, 0, PHASE_1_GREEN, PHASE_1);
    checkEq("short_pulse", {1'b0, pe_o[0]}, 2'd0);
    repeat (3) applyStimulus(1, 1, PHASE_1_GREEN, PHASE_1);
    checkEq("not_yet", {pe_o[0], pw_o[0]}, 2'b00);
    applyStimulus(1, 1, PHASE_1_GREEN, PHASE_1);
    checkEq("tie_latch", {pe_o[0], pw_o[0]}, 2'b11);
    applyStimulus(1, 0, PHASE_1_GREEN, PHASE_1);
    checkEq("tie_east_first", pri_o[0], 2'd1);
    applyStimulus(1, 0, PRIORITY_GREEN, EAST_PRIORITY);
    checkEq("serve_pulse", {1'b0, srv_o[0]}, 2'd1);
    checkEq("serve_pri", pri_o[0], 2'd0);
    checkEq("serve_clear", {pe_o[0], pw_o[0]}, 2'b01);
    applyStimulus(1, 0, PHASE_2_GREEN, PHASE_2);
    checkEq("pulse_one_cycle", {1'b0, srv_o[0]}, 2'd0);
    applyStimulus(1, 0, PHASE_1_GREEN, PHASE_1);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 0, PHASE_1_GREEN, PHASE_1);
      checkEq($sformatf("lockout_%0d", i), pri_o[0], 2'd0);
    end
    applyStimulus(1, 0, PHASE_1_GREEN, PHASE_1);
    checkEq("alternate_west", pri_o[0], 2'd2);
    checkEq("held_no_relatch", {1'b0, pe_o[0]}, 2'd0);
    applyStimulus(0, 0, PRIORITY_GREEN, WEST_PRIORITY);
    checkEq("west_served", {1'b0, srv_o[0]}, 2'd1);

    // Yellow hold.
    repeat (18) applyStimulus(0, 0, PHASE_1_GREEN, PHASE_1);
    repeat (4) applyStimulus(0, 1, PHASE_2_YELLOW, PHASE_2);
    checkEq("yellow_pending", {1'b0, pw_o[0]}, 2'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, PHASE_2_YELLOW, PHASE_2);
      checkEq($sformatf("yellow_hold_%0d", i), pri_o[0], 2'd0);
    end
    applyStimulus(0, 0, PHASE_2_RED, PHASE_2);
    checkEq("yellow_release", pri_o[0], 2'd2);

    // Randomized traffic with occasional asynchronous resets.
    re = 1'b0; rw = 1'b0; cp = PHASE_2; ls = PHASE_2_RED;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) re = ~re;
      if ($urandom_range(0, 5) == 0) rw = ~rw;
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3: cp = PHASE_1;
          4, 5:       cp = PHASE_2;
          6, 7:       cp = EAST_PRIORITY;
          default:    cp = WEST_PRIORITY;
        endcase
      end
      ls = 4'($urandom_range(0, 7));
      if (ls == PHASE_2_YELLOW && cp != PHASE_2) ls = PHASE_1_GREEN;
      if ($urandom_range(0, 599) == 0) doReset();
      else applyStimulus(re, rw, ls, cp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
